// File: rtl/macc_sched_pkg.sv
// rtl/macc_sched_pkg.sv - shared types and operand layout for the MACC request scheduler
package macc_sched_pkg;

  localparam int OPW    = 160;
  localparam int DW     = 32;
  // Operand bundle is {i6,i4,i3,i2,i1}; the core has no i5 input
  localparam int I1_LSB = 0;
  localparam int I2_LSB = 32;
  localparam int I3_LSB = 64;
  localparam int I4_LSB = 96;
  localparam int I6_LSB = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } sched_state_e;

endpackage

// File: rtl/macc_rr_arb.sv
// rtl/macc_rr_arb.sv - round-robin arbiter: first request at or after the pointer wins
module macc_rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    int w_j;
    w_j   = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    if (i_en) begin
      for (int i = 0; i < NREQ; i++) begin
        w_j = int'(i_ptr) + i;
        if (w_j >= NREQ) w_j = w_j - NREQ;
        if (!o_any && i_req[w_j]) begin
          o_any      = 1'b1;
          o_gnt[w_j] = 1'b1;
          o_idx      = PW'(w_j);
        end
      end
    end
  end

endmodule

// File: rtl/macc_req_scheduler.sv
// rtl/macc_req_scheduler.sv - shares one hls_macc core among NREQ requesters
// Optional watchdog enabled by MACC_SCHED_TIMEOUT_EN.
module macc_req_scheduler
  import macc_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_ops,
  output logic                core_start,
  input  logic                core_done,
  input  logic                core_idle,
  output logic [OPW-1:0]      core_ops,
  input  logic [DW-1:0]       core_o1,
  input  logic [DW-1:0]       core_o2,
  input  logic [DW-1:0]       core_ret,
  input  logic                core_o1_vld,
  input  logic                core_o2_vld,
  input  logic                core_ret_vld,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [DW-1:0]       rsp_o1,
  output logic [DW-1:0]       rsp_o2,
  output logic [DW-1:0]       rsp_ret,
  output logic                rsp_err,
`ifdef MACC_SCHED_TIMEOUT_EN
  output logic                timeout_pulse,
`endif
  output logic                busy
);

  localparam int PW = $clog2(NREQ);

  sched_state_e    r_state;
  sched_state_e    w_state_nxt;
  logic [PW-1:0]   r_rr_ptr;
  logic [OPW-1:0]  r_core_ops;
  logic [IDW-1:0]  r_rsp_id;
  logic [DW-1:0]   r_rsp_o1;
  logic [DW-1:0]   r_rsp_o2;
  logic [DW-1:0]   r_rsp_ret;
  logic            r_rsp_err;
  logic            w_arb_en;
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_gnt_idx;
  logic            w_gnt_any;
  logic            w_grant_take;
  logic            w_timeout;

  // Reset gates the arbiter so req_ready stays low while ap_rst_n is held
  assign w_arb_en     = (r_state == IDLE) && core_idle && ap_rst_n;
  assign w_grant_take = (r_state == IDLE) && w_gnt_any;

  macc_rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_gnt_any)
  );

`ifdef MACC_SCHED_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] r_tcnt;
  logic           r_timeout_pulse;

  assign w_timeout     = (r_state == RUN) && !core_done && (r_tcnt == TCW'(TIMEOUT - 1));
  assign timeout_pulse = r_timeout_pulse;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_tcnt          <= '0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_timeout_pulse <= w_timeout;
      if (w_grant_take) begin
        r_tcnt <= '0;
      end else if (r_state == RUN) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_gnt_any) w_state_nxt = RUN;
      RUN:  if (core_done || w_timeout) w_state_nxt = RESP;
      RESP: if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rr_ptr   <= '0;
      r_core_ops <= '0;
      r_rsp_id   <= '0;
      r_rsp_o1   <= '0;
      r_rsp_o2   <= '0;
      r_rsp_ret  <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_grant_take) begin
        r_core_ops <= req_ops[int'(w_gnt_idx)*OPW +: OPW];
        r_rsp_id   <= IDW'(w_gnt_idx);
        r_rr_ptr   <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
      end
      if (r_state == RUN && core_done) begin
        r_rsp_o1  <= core_o1;
        r_rsp_o2  <= core_o2;
        r_rsp_ret <= core_ret;
        r_rsp_err <= ~(core_o1_vld & core_o2_vld & core_ret_vld);
      end else if (w_timeout) begin
        r_rsp_o1  <= '0;
        r_rsp_o2  <= '0;
        r_rsp_ret <= '0;
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign req_ready  = w_gnt;
  assign core_start = (r_state == RUN);
  assign rsp_valid  = (r_state == RESP);
  assign busy       = (r_state != IDLE);
  assign core_ops   = r_core_ops;
  assign rsp_id     = r_rsp_id;
  assign rsp_o1     = r_rsp_o1;
  assign rsp_o2     = r_rsp_o2;
  assign rsp_ret    = r_rsp_ret;
  assign rsp_err    = r_rsp_err;

endmodule
